mem_stage: RTL and testbench

Memory-access pipeline stage of the five-stage MIPS core, between EX and WB. Registers the EX→MEM bus under stall control and turns the synchronous data-SRAM read word into the final register-file write value, with byte/halfword extraction and sign or zero extension. Drives the MEM→WB bus and a forwarding bus back to ID. Holds the SRAM read word across MEM stalls so a stalled load does not lose its data.

---
 rtl/mem_stage_pkg.sv | 51 +++++
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage_load_ext.sv | 41 ++++
 rtl/mem_stage.sv | 77 +++++++
 tb/tb_mem_stage.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, mem_op codes and bus layouts for the MEM stage.
// No logic, so no latency of its own.
// No flow control here; stall handling lives in mem_stage.
package mem_stage_pkg;

    localparam int EX_TO_MEM_WD = 79;
    localparam int MEM_TO_WB_WD = 70;
    localparam int MEM_TO_ID_WD = 38;
    localparam int StallBus     = 6;

    // Positions of the MEM and WB entries in the stall vector.
    localparam int STALL_MEM = 3;
    localparam int STALL_WB  = 4;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Load flavours; codes 5..7 are not defined and fall back to a word load.
    typedef enum logic [2:0] {
        MEMOP_LW  = 3'd0,
        MEMOP_LB  = 3'd1,
        MEMOP_LBU = 3'd2,
        MEMOP_LH  = 3'd3,
        MEMOP_LHU = 3'd4
    } mem_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  mem_op;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_id_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundles the stall vector, EX->MEM bus, SRAM read word and MEM's outgoing buses.
// Pure wiring, zero latency.
// Backpressure arrives as the stall vector; the slave side honours it.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic [StallBus-1:0]     stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

    // The MEM stage itself.
    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_id_bus
    );

    // The surrounding pipeline (EX, SRAM, WB, ID).
    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_id_bus
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Selects a byte/halfword/word from a little-endian SRAM word and sign/zero extends it.
// Purely combinational, zero latency.
// No flow control; usable wherever a load value must be formed, e.g. a load-use bypass.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_mem_op,
    output logic [31:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane chosen by both address bits, halfword lane by bit 1 only;
    // misaligned accesses simply use whatever lane these bits pick.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extension by load flavour; undefined codes behave as a word load.
    always_comb begin
        o_value = i_word;
        case (i_mem_op)
            MEMOP_LB:  o_value = {{24{w_byte[7]}}, w_byte};
            MEMOP_LBU: o_value = {24'h000000, w_byte};
            MEMOP_LH:  o_value = {{16{w_half[15]}}, w_half};
            MEMOP_LHU: o_value = {16'h0000, w_half};
            default:   o_value = i_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX->MEM bus and forms the register-file write value.
// One register stage after EX; load data is combinational from the SRAM word in that cycle.
// MEM stall holds the register and freezes the SRAM word; MEM stall with WB running inserts a bubble.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);

    ex_to_mem_t  r_ex_to_mem;
    logic [31:0] r_rdata_hold;
    logic        r_hold_vld;

    logic        w_stall_mem;
    logic        w_stall_wb;
    logic [31:0] w_word;
    logic [31:0] w_load_val;
    logic [31:0] w_rf_wdata;
    logic        w_unused;

    assign w_stall_mem = bus.stall[STALL_MEM];
    assign w_stall_wb  = bus.stall[STALL_WB];

    // Pipeline register: bubble when MEM stops but WB keeps going, load when MEM runs, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_to_mem <= '0;
        end else if (w_stall_mem == Stop && w_stall_wb == NoStop) begin
            r_ex_to_mem <= '0;
        end else if (w_stall_mem == NoStop) begin
            r_ex_to_mem <= bus.ex_to_mem_bus;
        end
    end

    // Hold flag: set on the first stalled edge, cleared as soon as MEM advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_vld <= 1'b0;
        end else if (w_stall_mem == Stop && !r_hold_vld) begin
            r_hold_vld <= 1'b1;
        end else if (w_stall_mem == NoStop) begin
            r_hold_vld <= 1'b0;
        end
    end

    // Held SRAM word: the SRAM only presents the read for one cycle, so capture it on the
    // first stalled edge; its contents only matter while the flag is set.
    always_ff @(posedge clk) begin
        if (w_stall_mem == Stop && !r_hold_vld) begin
            r_rdata_hold <= bus.data_sram_rdata;
        end
    end

    assign w_word = r_hold_vld ? r_rdata_hold : bus.data_sram_rdata;

    mem_stage_load_ext u_load_ext (
        .i_word   (w_word),
        .i_addr   (r_ex_to_mem.ex_result[1:0]),
        .i_mem_op (r_ex_to_mem.mem_op),
        .o_value  (w_load_val)
    );

    // Loads write the extracted value; stores and ALU ops pass the EX result through.
    assign w_rf_wdata = r_ex_to_mem.sel_rf_res ? w_load_val : r_ex_to_mem.ex_result;

    assign bus.mem_to_wb_bus = {r_ex_to_mem.pc, r_ex_to_mem.rf_we,
                                r_ex_to_mem.rf_waddr, w_rf_wdata};
    assign bus.mem_to_id_bus = {r_ex_to_mem.rf_we, r_ex_to_mem.rf_waddr, w_rf_wdata};

    // SRAM control belongs to EX; those fields and the other stages' stall bits are carried
    // here only as part of the bus layout.
    assign w_unused = ^{r_ex_to_mem.data_ram_en, r_ex_to_mem.data_ram_wen,
                        bus.stall[2:0], bus.stall[5]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mem_stage_if u_if ();

    mem_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [78:0] mk_ex(input logic [31:0] pc, input logic [2:0] op,
                                          input logic en, input logic [3:0] wen,
                                          input logic sel, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] res);
        return {pc, op, en, wen, sel, we, waddr, res};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                          input logic [4:0] waddr, input logic [31:0] wd);
        return {pc, we, waddr, wd};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_op  [6];
    logic [1:0]  ld_addr[6];
    logic [31:0] ld_exp [6];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ld_op[0] = 3'd1; ld_addr[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
        ld_op[1] = 3'd2; ld_addr[1] = 2'd3; ld_exp[1] = 32'h0000_0080;
        ld_op[2] = 3'd1; ld_addr[2] = 2'd0; ld_exp[2] = 32'h0000_0001;
        ld_op[3] = 3'd3; ld_addr[3] = 2'd2; ld_exp[3] = 32'hFFFF_80FF;
        ld_op[4] = 3'd4; ld_addr[4] = 2'd0; ld_exp[4] = 32'h0000_7F01;
        ld_op[5] = 3'd0; ld_addr[5] = 2'd0; ld_exp[5] = 32'h80FF_7F01;

        // Reset with a live input bus.
        rst = 1'b1;
        u_if.stall = '0;
        u_if.data_sram_rdata = 32'hFFFF_FFFF;
        u_if.ex_to_mem_bus = mk_ex(32'hBFC0_0004, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, 32'hAAAA_5555);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_wb", u_if.mem_to_wb_bus, 70'h0);
            check("rst_id", u_if.mem_to_id_bus, 70'h0);
        end

        // Reset wins over a bubble-inducing stall.
        u_if.stall = 6'b001000;
        step();
        check("rst_vs_stall", u_if.mem_to_wb_bus, 70'h0);
        rst = 1'b0;
        u_if.stall = '0;

        // ALU pass-through.
        u_if.ex_to_mem_bus = mk_ex(32'hBFC0_0010, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h1234_5678);
        step();
        check("pass_wb", u_if.mem_to_wb_bus, mk_wb(32'hBFC0_0010, 1'b1, 5'd8, 32'h1234_5678));
        check("pass_id", u_if.mem_to_id_bus, {32'h0, 1'b1, 5'd8, 32'h1234_5678});

        // Store passes ex_result, ignores the SRAM word.
        u_if.ex_to_mem_bus = mk_ex(32'hBFC0_0014, 3'd0, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_1003);
        step();
        check("store_wb", u_if.mem_to_wb_bus, mk_wb(32'hBFC0_0014, 1'b0, 5'd0, 32'h0000_1003));

        // Loads against a fixed SRAM word.
        for (int i = 0; i < 6; i++) begin
            u_if.ex_to_mem_bus = mk_ex(32'hBFC0_0020 + 32'(i * 4), ld_op[i], 1'b1, 4'h0, 1'b1, 1'b1,
                                       5'd9, {30'h0400_0000, ld_addr[i]});
            u_if.data_sram_rdata = 32'h0;
            step();
            u_if.data_sram_rdata = 32'h80FF_7F01;
            #1;
            check($sformatf("load%0d", i), u_if.mem_to_wb_bus,
                  mk_wb(32'hBFC0_0020 + 32'(i * 4), 1'b1, 5'd9, ld_exp[i]));
        end
        check("load_id", u_if.mem_to_id_bus, {32'h0, 1'b1, 5'd9, 32'h80FF_7F01});

        // Stall hold: LW enters, then MEM and WB both stop for 3 edges.
        u_if.ex_to_mem_bus = mk_ex(32'hBFC0_0040, 3'd0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd10, 32'h0000_2000);
        step();
        u_if.data_sram_rdata = 32'hDEAD_BEEF;
        u_if.stall = 6'b011000;
        u_if.ex_to_mem_bus = mk_ex(32'hBFC0_0044, 3'd2, 1'b1, 4'h0, 1'b1, 1'b1, 5'd11, 32'h0000_3001);
        #1;
        check("stall_c0", u_if.mem_to_wb_bus, mk_wb(32'hBFC0_0040, 1'b1, 5'd10, 32'hDEAD_BEEF));
        for (int i = 0; i < 3; i++) begin
            step();
            u_if.data_sram_rdata = 32'h0;
            #1;
            check($sformatf("stall_c%0d", i + 1), u_if.mem_to_wb_bus,
                  mk_wb(32'hBFC0_0040, 1'b1, 5'd10, 32'hDEAD_BEEF));
        end

        // Bubble: MEM stops, WB runs.
        u_if.stall = 6'b001000;
        step();
        check("bubble_wb", u_if.mem_to_wb_bus, 70'h0);
        check("bubble_id", u_if.mem_to_id_bus, 70'h0);

        // Release as LBU addr 0 enters; must use live data, not the held 0xDEADBEEF.
        u_if.stall = '0;
        u_if.ex_to_mem_bus = mk_ex(32'hBFC0_0048, 3'd2, 1'b1, 4'h0, 1'b1, 1'b1, 5'd12, 32'h0000_4000);
        step();
        u_if.data_sram_rdata = 32'h0000_00AB;
        #1;
        check("release_wb", u_if.mem_to_wb_bus, mk_wb(32'hBFC0_0048, 1'b1, 5'd12, 32'h0000_00AB));

        // Next instruction after release flows normally.
        u_if.ex_to_mem_bus = mk_ex(32'hBFC0_004C, 3'd0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd13, 32'h0BAD_F00D);
        step();
        check("after_release", u_if.mem_to_wb_bus, mk_wb(32'hBFC0_004C, 1'b1, 5'd13, 32'h0BAD_F00D));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
